calc_execute_unit: RTL

Execute stage downstream of the calculator control LUT. Consumes the 3-bit funct opcode (ADD/SUB/MULT/DIV and the ToPrev variants), performs signed two's-complement arithmetic and maintains the previous-result register that ToPrev operations chain from. Add/sub complete in a single execute cycle. Mult/div are iterative and run one bit per cycle, behind a start/busy/done handshake.

---
 rtl/calc_pkg.sv | 30 +++
 rtl/calc_muldiv_core.sv | 84 ++++++++
 rtl/calc_execute_unit.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator execute stage: opcode encodings,
// FSM state encoding and the default datapath width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    // funct[2]=1 takes operand_a as the left operand, funct[2]=0 chains from prev_result
    localparam logic [2:0] FN_ADD             = {1'b1, OP_ADD};
    localparam logic [2:0] FN_SUB             = {1'b1, OP_SUB};
    localparam logic [2:0] FN_MULT            = {1'b1, OP_MULT};
    localparam logic [2:0] FN_DIV             = {1'b1, OP_DIV};
    localparam logic [2:0] FN_ADD_TO_PREV     = {1'b0, OP_ADD};
    localparam logic [2:0] FN_SUB_TO_PREV     = {1'b0, OP_SUB};
    localparam logic [2:0] FN_MULT_WITH_PREV  = {1'b0, OP_MULT};
    localparam logic [2:0] FN_DIV_BY_PREV     = {1'b0, OP_DIV};

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDSUB = 3'd1,
        MUL    = 3'd2,
        DIV    = 3'd3,
        DONE   = 3'd4
    } calcStateT;

endpackage

// File: rtl/calc_muldiv_core.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// The first iteration is folded into the load edge so WIDTH steps finish WIDTH-1 edges later.
module calc_muldiv_core #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     magA,
    input  logic [WIDTH-1:0]     magB,
    output logic                 busy,
    output logic                 finish,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]      count;
    logic               modeReg;
    logic               stepMode;
    logic               stepEn;
    logic [2*WIDTH-1:0] acc, mcand, srcAcc, srcMcand, nxtAcc;
    logic [WIDTH-1:0]   mplier, srcMplier;
    logic [WIDTH-1:0]   rem, quo, divisor, srcRem, srcQuo, srcDiv, nxtRem, nxtQuo;
    logic [WIDTH:0]     trial;

    assign finish   = busy && (count == CW'(WIDTH));
    assign stepEn   = load || (busy && !finish);
    assign stepMode = load ? mode : modeReg;
    assign product  = acc;
    assign quotient = quo;

    always_comb begin
        srcAcc    = load ? '0 : acc;
        srcMcand  = load ? {{WIDTH{1'b0}}, magA} : mcand;
        srcMplier = load ? magB : mplier;
        srcRem    = load ? '0 : rem;
        srcQuo    = load ? magA : quo;
        srcDiv    = load ? magB : divisor;

        nxtAcc = srcMplier[0] ? srcAcc + srcMcand : srcAcc;

        // Remainder stays below the divisor, so WIDTH bits hold it after each step
        trial = {srcRem, srcQuo[WIDTH-1]};
        if (trial >= {1'b0, srcDiv}) begin
            nxtRem = WIDTH'(trial - {1'b0, srcDiv});
            nxtQuo = {srcQuo[WIDTH-2:0], 1'b1};
        end else begin
            nxtRem = trial[WIDTH-1:0];
            nxtQuo = {srcQuo[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= 1'b0;
            count <= '0;
        end else if (load) begin
            busy  <= 1'b1;
            count <= CW'(1);
        end else if (busy) begin
            if (finish) busy <= 1'b0;
            else        count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load) modeReg <= mode;
        if (stepEn) begin
            if (stepMode) begin
                rem     <= nxtRem;
                quo     <= nxtQuo;
                divisor <= srcDiv;
            end else begin
                acc    <= nxtAcc;
                mcand  <= srcMcand << 1;
                mplier <= srcMplier >> 1;
            end
        end
    end

endmodule

// File: rtl/calc_execute_unit.sv
// Calculator execute stage: single-cycle add/sub, iterative mul/div, and the
// previous-result register that the ToPrev opcodes chain from.
module calc_execute_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] prev_result,
    output logic             overflow,
    output logic             div_by_zero
);

    calcStateT state, nextState;

    logic                    accept;
    logic [WIDTH-1:0]        leftSel;
    logic signed [WIDTH-1:0] leftOp, rightOp;
    logic                    subOp, negOut, zeroDiv;
    logic                    coreBusy, coreFinish;
    logic [2*WIDTH-1:0]      coreProduct;
    logic [WIDTH-1:0]        coreQuotient;
    logic [WIDTH:0]          addSubRes, mulRes, divRes;

    function automatic logic [WIDTH-1:0] absMag(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? WIDTH'(-x) : x;
    endfunction

    // Returns {overflow, sum}; the extra bit catches any signed wrap, including subtracting the most-negative value
    function automatic logic [WIDTH:0] addSubFn(input logic signed [WIDTH-1:0] l,
                                                input logic signed [WIDTH-1:0] r,
                                                input logic sub);
        logic signed [WIDTH:0] ext;
        if (sub) ext = $signed({l[WIDTH-1], l}) - $signed({r[WIDTH-1], r});
        else     ext = $signed({l[WIDTH-1], l}) + $signed({r[WIDTH-1], r});
        return {ext[WIDTH] ^ ext[WIDTH-1], ext[WIDTH-1:0]};
    endfunction

    function automatic logic [WIDTH:0] mulFinal(input logic [2*WIDTH-1:0] mag, input logic neg);
        logic [2*WIDTH-1:0] full;
        logic [WIDTH:0]     hi;
        full = neg ? -mag : mag;
        hi   = full[2*WIDTH-1:WIDTH-1];
        return {!((&hi) || !(|hi)), full[WIDTH-1:0]};
    endfunction

    // Only most-negative / -1 yields a positive quotient of 2^(WIDTH-1)
    function automatic logic [WIDTH:0] divFinal(input logic [WIDTH-1:0] q, input logic neg);
        return {!neg && q[WIDTH-1], neg ? WIDTH'(-q) : q};
    endfunction

    assign accept    = (state == IDLE) && start;
    assign leftSel   = funct[2] ? operand_a : prev_result;
    assign addSubRes = addSubFn(leftOp, rightOp, subOp);
    assign mulRes    = mulFinal(coreProduct, negOut);
    assign divRes    = divFinal(coreQuotient, negOut);
    assign busy      = (state != IDLE) || coreBusy;
    assign done      = (state == DONE);

    calc_muldiv_core #(.WIDTH(WIDTH)) uCore (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && funct[1]),
        .mode     (funct[0]),
        .magA     (absMag(leftSel)),
        .magB     (absMag(operand_b)),
        .busy     (coreBusy),
        .finish   (coreFinish),
        .product  (coreProduct),
        .quotient (coreQuotient)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            leftOp  <= leftSel;
            rightOp <= operand_b;
            subOp   <= funct[0];
            negOut  <= leftSel[WIDTH-1] ^ operand_b[WIDTH-1];
            zeroDiv <= (operand_b == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start) begin
                    case (funct[1:0])
                        OP_MULT: nextState = MUL;
                        OP_DIV:  nextState = DIV;
                        default: nextState = ADDSUB;
                    endcase
                end
            end
            ADDSUB:  nextState = DONE;
            MUL:     if (coreFinish) nextState = DONE;
            DIV:     if (coreFinish) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Result registers update on the edge entering DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            result      <= '0;
            prev_result <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ADDSUB: begin
                    {overflow, result} <= addSubRes;
                    prev_result        <= addSubRes[WIDTH-1:0];
                    div_by_zero        <= 1'b0;
                end
                MUL: if (coreFinish) begin
                    {overflow, result} <= mulRes;
                    prev_result        <= mulRes[WIDTH-1:0];
                    div_by_zero        <= 1'b0;
                end
                DIV: if (coreFinish) begin
                    if (zeroDiv) begin
                        result      <= '0;
                        overflow    <= 1'b0;
                        div_by_zero <= 1'b1;
                    end else begin
                        {overflow, result} <= divRes;
                        prev_result        <= divRes[WIDTH-1:0];
                        div_by_zero        <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
